// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the
// multi-digit keypad calculator.
package calc_pkg;

  typedef enum logic [2:0] {
    WAIT_A = 3'd0,
    WAIT_B = 3'd1,
    MULT   = 3'd2,
    PRINT  = 3'd3,
    ERROR  = 3'd4
  } state_e;

  localparam logic [3:0] CMD_ADD = 4'hA;
  localparam logic [3:0] CMD_SUB = 4'hB;
  localparam logic [3:0] CMD_MUL = 4'hC;
  localparam logic [3:0] CMD_CLR = 4'hD;
  localparam logic [3:0] CMD_EQ  = 4'hE;
  localparam logic [3:0] CMD_BS  = 4'hF;

  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_PRINT = 2'b11;

  localparam logic [3:0] ERR_DIGIT = 4'hE;

  function automatic logic is_op(
    input logic [3:0] c
  );
    return (c == CMD_ADD) || (c == CMD_SUB) ||
           (c == CMD_MUL);
  endfunction

endpackage

// File: rtl/calc_disp_serializer.sv
// calc_disp_serializer: emits a value one decimal
// digit per cycle, least significant position first.
module calc_disp_serializer
  import calc_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int W      = $clog2(10**DIGITS),
  parameter int PW     = $clog2(DIGITS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  value,
  input  logic          err,
  output logic [3:0]    data,
  output logic [PW-1:0] pos,
  output logic          disp_valid,
  output logic          done
);

  logic [W-1:0]  shadow_q, shadow_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          err_q, err_d;
  logic [3:0]    data_q, data_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          dv_q, dv_d;

  // load on start, then peel one digit per cycle
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    err_d    = err_q;
    data_d   = data_q;
    pos_d    = pos_q;
    dv_d     = 1'b0;
    if (start) begin
      shadow_d = value;
      err_d    = err;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      data_d   = err_q ? ERR_DIGIT
               : 4'(shadow_q % W'(10));
      pos_d    = cnt_q;
      dv_d     = 1'b1;
      shadow_d = shadow_q / W'(10);
      if (cnt_q == PW'(DIGITS-1))
        run_d = 1'b0;
      else
        cnt_d = cnt_q + PW'(1);
    end
  end

  // serializer state and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      pos_q    <= '0;
      dv_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      err_q    <= err_d;
      data_q   <= data_d;
      pos_q    <= pos_d;
      dv_q     <= dv_d;
    end
  end

  assign data       = data_q;
  assign pos        = pos_q;
  assign disp_valid = dv_q;
  assign done = dv_q && (pos_q == PW'(DIGITS-1));

endmodule

// File: rtl/calc_multi.sv
// calc_multi: keypad calculator with decimal entry,
// add/sub, shift-add multiply and digit display.
module calc_multi
  import calc_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int W      = $clog2(10**DIGITS),
  parameter int PW     = $clog2(DIGITS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [3:0]    cmd,
  output logic          cmd_ready,
  output logic [1:0]    status,
  output logic [3:0]    data,
  output logic [PW-1:0] pos,
  output logic          disp_valid,
  output logic [2:0]    state
);

  localparam int CW = $clog2(W+1);
  localparam logic [W-1:0] MAXW = W'(10**DIGITS-1);

  state_e          state_q, state_d;
  state_e          next_q, next_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    entry_q, entry_d;
  logic [3:0]      op_q, op_d;
  logic            fresh_q, fresh_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [CW-1:0]   mcnt_q, mcnt_d;
  logic            fin_q, fin_d;

  logic            accept;
  logic            start, start_err;
  logic            done;
  logic [W+3:0]    app;
  logic [W:0]      sum;

  assign accept = cmd_valid && cmd_ready;
  assign app = {4'b0, entry_q} * (W+4)'(10)
             + {{W{1'b0}}, cmd};
  assign sum = {1'b0, a_q} + {1'b0, entry_q};

  // command decode, arithmetic and next state
  always_comb begin
    state_d   = state_q;
    next_d    = next_q;
    a_d       = a_q;
    b_d       = b_q;
    entry_d   = entry_q;
    op_d      = op_q;
    fresh_d   = fresh_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mcnt_d    = mcnt_q;
    fin_d     = fin_q;
    start     = 1'b0;
    start_err = 1'b0;
    if (accept && cmd == CMD_CLR) begin
      a_d     = '0;
      b_d     = '0;
      entry_d = '0;
      op_d    = '0;
      fresh_d = 1'b0;
      start   = 1'b1;
      state_d = PRINT;
      next_d  = WAIT_A;
    end else begin
      unique case (state_q)
        WAIT_A, WAIT_B: if (accept) begin
          start   = 1'b1;
          state_d = PRINT;
          next_d  = state_q;
          unique case (1'b1)
            cmd < 4'd10: begin
              fresh_d = 1'b0;
              if (fresh_q)
                entry_d = {{(W-4){1'b0}}, cmd};
              else if (app <= {4'b0, MAXW})
                entry_d = app[W-1:0];
            end
            cmd == CMD_BS: begin
              entry_d = entry_q / W'(10);
              fresh_d = 1'b0;
            end
            is_op(cmd): begin
              op_d    = cmd;
              fresh_d = 1'b0;
              if (state_q == WAIT_A) begin
                a_d     = entry_q;
                entry_d = '0;
                next_d  = WAIT_B;
              end
            end
            cmd == CMD_EQ: if (state_q == WAIT_B) begin
              b_d = entry_q;
              if (op_q == CMD_MUL) begin
                start   = 1'b0;
                state_d = MULT;
                acc_d   = '0;
                mcand_d = {{W{1'b0}}, a_q};
                mcnt_d  = '0;
              end else if (op_q == CMD_SUB) begin
                if (a_q < entry_q) begin
                  start_err = 1'b1;
                  next_d    = ERROR;
                end else begin
                  entry_d = a_q - entry_q;
                  fresh_d = 1'b1;
                  next_d  = WAIT_A;
                end
              end else begin
                if (sum > {1'b0, MAXW}) begin
                  start_err = 1'b1;
                  next_d    = ERROR;
                end else begin
                  entry_d = sum[W-1:0];
                  fresh_d = 1'b1;
                  next_d  = WAIT_A;
                end
              end
            end
            default: ;
          endcase
        end
        MULT: begin
          if (b_q[0])
            acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
          mcnt_d  = mcnt_q + CW'(1);
          if (mcnt_q == CW'(W-1)) begin
            state_d = PRINT;
            fin_d   = 1'b1;
          end
        end
        PRINT: begin
          if (fin_q) begin
            fin_d = 1'b0;
            start = 1'b1;
            if (acc_q > {{W{1'b0}}, MAXW}) begin
              start_err = 1'b1;
              next_d    = ERROR;
            end else begin
              entry_d = acc_q[W-1:0];
              fresh_d = 1'b1;
              next_d  = WAIT_A;
            end
          end else if (done) begin
            state_d = next_q;
          end
        end
        ERROR: ;
        default: state_d = WAIT_A;
      endcase
    end
  end

  // architectural registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_A;
      next_q  <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      entry_q <= '0;
      op_q    <= '0;
      fresh_q <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      mcnt_q  <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      a_q     <= a_d;
      b_q     <= b_d;
      entry_q <= entry_d;
      op_q    <= op_d;
      fresh_q <= fresh_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mcnt_q  <= mcnt_d;
      fin_q   <= fin_d;
    end
  end

  // status follows the current state
  always_comb begin
    status    = ST_READY;
    cmd_ready = 1'b0;
    unique case (state_q)
      WAIT_A, WAIT_B: cmd_ready = 1'b1;
      MULT:  status = ST_BUSY;
      PRINT: status = ST_PRINT;
      ERROR: begin
        status    = ST_ERR;
        cmd_ready = 1'b1;
      end
      default: status = ST_ERR;
    endcase
  end

  assign state = state_q;

  calc_disp_serializer #(
    .DIGITS (DIGITS),
    .W      (W),
    .PW     (PW)
  ) u_ser (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .value      (entry_d),
    .err        (start_err),
    .data       (data),
    .pos        (pos),
    .disp_valid (disp_valid),
    .done       (done)
  );

endmodule

// File: tb/tb_calc_multi.sv
// tb_calc_multi: scoreboard bench for calc_multi
// against an integer reference model.
module tb_calc_multi;

  localparam int D  = 8;
  localparam int W  = $clog2(10**D);
  localparam int PW = $clog2(D);

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [3:0]    cmd;
  logic          cmd_ready;
  logic [1:0]    status;
  logic [3:0]    data;
  logic [PW-1:0] pos;
  logic          disp_valid;
  logic [2:0]    state;

  always #5 clock = ~clock;

  calc_multi #(.DIGITS(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .status     (status),
    .data       (data),
    .pos        (pos),
    .disp_valid (disp_valid),
    .state      (state)
  );

  int total = 0;
  int bad   = 0;
  int expq[$];

  longint ma, me, maxv;
  int     mop, mst;
  bit     mfresh;
  int     exp_lat;
  bit     exp_mul;
  bit     poke = 0;

  function automatic longint p10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  task automatic check(input string name,
                       input longint act,
                       input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               name, act, req);
    end
  endtask

  function automatic void push_print(
    input longint v, input bit err);
    for (int p = 0; p < D; p++)
      expq.push_back(p * 16 +
        (err ? 14 : int'((v / p10(p)) % 10)));
  endfunction

  function automatic void model_reset();
    ma = 0; me = 0; mop = 0;
    mfresh = 0; mst = 0;
  endfunction

  function automatic void model(input int c);
    longint r;
    bit er;
    exp_mul = 0;
    exp_lat = D + 1;
    if (c == 13) begin
      model_reset();
      push_print(0, 0);
    end else if (mst == 2) begin
      exp_lat = 0;
    end else if (c < 10) begin
      if (mfresh) begin
        me = c; mfresh = 0;
      end else if (me * 10 + c <= maxv) begin
        me = me * 10 + c;
      end
      push_print(me, 0);
    end else if (c == 15) begin
      me = me / 10; mfresh = 0;
      push_print(me, 0);
    end else if (c >= 10 && c <= 12) begin
      if (mst == 0) begin
        ma = me; me = 0; mst = 1;
      end
      mop = c; mfresh = 0;
      push_print(me, 0);
    end else if (mst == 0) begin
      push_print(me, 0);
    end else begin
      er = 0;
      if (mop == 10) r = ma + me;
      else if (mop == 11) begin
        if (ma < me) er = 1;
        r = ma - me;
      end else begin
        r = ma * me;
        exp_mul = 1;
        exp_lat = W + D + 2;
      end
      if (r > maxv) er = 1;
      if (er) begin
        mst = 2;
        push_print(0, 1);
      end else begin
        me = r; mfresh = 1; mst = 0;
        push_print(me, 0);
      end
    end
  endfunction

  always @(negedge clock) begin
    if (!reset && disp_valid) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_print: pos=%0d data=%0d",
                 pos, data);
      end else begin
        int e;
        e = expq.pop_front();
        check("print_pos", pos, e / 16);
        check("print_data", data, e % 16);
      end
    end
  end

  task automatic send(input int c);
    int n, busy;
    model(c);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd = 4'(c);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    busy = 0;
    if (exp_lat > 0)
      check("status_e0", status, exp_mul ? 1 : 3);
    while (!cmd_ready && n < 400) begin
      if (status == 2'b01) busy++;
      if (poke && n == 2) begin
        cmd_valid = 1'b1;
        cmd = 4'd9;
      end
      if (poke && n == 4) cmd_valid = 1'b0;
      @(posedge clock);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("latency", n, exp_lat);
    check("busy_cycles", busy, exp_mul ? W : 0);
    check("status_idle", status, mst == 2 ? 0 : 2);
    check("queue_drained", expq.size(), 0);
  endtask

  task automatic send_num(input longint v);
    int ds[$];
    if (v == 0) ds.push_back(0);
    while (v > 0) begin
      ds.push_front(int'(v % 10));
      v = v / 10;
    end
    foreach (ds[i]) send(ds[i]);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    maxv = p10(D) - 1;
    model_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd = 4'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_state", state, 0);
    check("rst_status", status, 2);
    check("rst_ready", cmd_ready, 1);
    check("rst_dv", disp_valid, 0);
    check("rst_data", data, 0);
    check("rst_pos", pos, 0);
    @(negedge clock);
    reset = 1'b0;

    send(1); send(2); send(3);

    send(13);
    send_num(45); send(10);
    send_num(55); send(14);
    send(7);

    send(13);
    send_num(123); send(12);
    send_num(1000); send(14);

    send(13);
    send_num(99999999); send(10);
    send(1); send(14);
    send(5);
    send(13);

    send(5); send(11); send(9); send(14);
    send(13);
    send_num(12345678);
    send(9);
    send(15);
    poke = 1;
    send(4);
    poke = 0;
    send(14);

    send(13);
    send_num(12); send(12); send_num(34);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd = 4'd14;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("mid_mul_busy", status, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_status", status, 2);
    check("mid_rst_dv", disp_valid, 0);
    check("mid_rst_ready", cmd_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    expq.delete();

    send(13);
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) send($urandom_range(0, 9));
      else if (r < 65) send(10);
      else if (r < 70) send(11);
      else if (r < 75) send(12);
      else if (r < 88) send(14);
      else if (r < 94) send(15);
      else send(13);
    end

    check("final_queue", expq.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
